banner_scan_controller: RTL and testbench
=========================================

Name: banner_scan_controller

Overview:
- Scheduler for a 4-digit multiplexed 7-segment display.
- Time-shares one 4-bit→7-segment decoder across four anodes.
- Rotates a 10-character message buffer across the display (banner), with enable and direction control.
- Message is loaded through a valid/ready write port into a shadow buffer and committed tear-free at a frame boundary.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (≥2).
- ROT_DIV, 25: scan frames (4 slots each) per rotation step (≥1).
- MSG_LEN, 10: message length in characters (4..16).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  rotation enable
- dir  input  1  rotation direction (1 = left, offset+1; 0 = right, offset−1)
- wr_valid  input  1  shadow-buffer write request
- wr_ready  output  1  write accepted when wr_valid & wr_ready
- wr_addr  input  4  character index; values ≥ MSG_LEN are accepted and dropped
- wr_data  input  4  character code; 0-9 are digits, 10-15 show blank
- commit  input  1  single-cycle pulse: copy shadow→active at next frame end
- segment  output  7  active-high segments, bit0 = a … bit6 = g
- anode  output  4  active-low, one-cold; anode[3] is leftmost
- offset  output  4  current rotation offset, 0..MSG_LEN−1

Behaviour:
- Reset (async assert, sync release):
  - anode = 4'b1111, segment = 0, offset = 0, wr_ready = 0.
  - Both buffers filled with 4'hF (blank).
  - Scan and rotation counters cleared; commit FSM = IDLE.
  - First cycle after release: wr_ready = 1.
- Scan timing:
  - Prescaler counts 0..SCAN_DIV−1; terminal count = slot tick.
  - Slot index s counts 3→0 and wraps 0→3; one wrap = frame end.
- Display mapping:
  - Position p (anode[p]) shows active[(offset + (3−p)) mod MSG_LEN].
  - anode and segment are registered; both update exactly 1 cycle after the slot tick, in the same cycle.
  - Codes 10-15 force segment = 0 while the anode stays active.
- Rotation:
  - Rotation counter increments at each frame end while en = 1; it holds while en = 0.
  - At terminal count (ROT_DIV−1) with en = 1: counter clears and offset steps by ±1 mod MSG_LEN (MSG_LEN−1 → 0 going left, 0 → MSG_LEN−1 going right).
  - dir is sampled at the frame end.
- Commit FSM (IDLE, PENDING):
  - In IDLE, each accepted write stores wr_data at shadow[wr_addr].
  - commit in IDLE → PENDING; wr_ready = 0 while PENDING.
  - At the next frame end: copy shadow→active, clear offset to 0, clear the rotation counter, return to IDLE.
  - Commit wins over a rotation step in the same frame end.
  - commit while already PENDING is ignored.
  - commit and an accepted write in the same IDLE cycle: the write lands first and is included in the copy.
- Writes never alter what is currently displayed until commit.
- Asserting reset mid-frame or mid-PENDING aborts immediately; the pending commit is lost.

Optional Feature:
- Macro SCAN_GHOST_GUARD_EN.
- Defined: each slot tick first drives anode = 4'b1111 and segment = 0 for one clock, then the new digit on the following clock, suppressing ghosting. Display update latency becomes 2 cycles after the tick.
- Undefined: direct switch, 1-cycle latency, no blank cycle.

Decomposition:
- Package banner_pkg holds:
  - constants MSG_LEN_MAX = 16, BLANK_CODE = 4'hF, ANODE_OFF = 4'b1111;
  - typedef commit_state_t {IDLE, PENDING};
  - typedef char_t (4-bit).
- Sub-module banner_scan_timer: prescaler, slot index, slot_tick and frame_end strobes.
- Controller instantiates the team's existing 4-bit 7-segment decoder for segment generation.

Test Plan (SCAN_DIV = 4, ROT_DIV = 2, MSG_LEN = 10):
- Reset → all outputs at reset values; release, write "0123456789" to addr 0..9, commit → after the next frame end, anode[3..0] cycle shows 0,1,2,3; codes 0/1 give segment 7'h3F / 7'h06.
- en = 1, dir = 1 for 2 frames → offset = 1, display 1,2,3,4; from offset 9 the next step gives offset 0; display at offset 9 is 9,0,1,2.
- dir = 0 at offset 0 → offset 9 after 2 frames; en = 0 → offset frozen over 10 frames.
- Write to addr 12 and code 4'hB at addr 0, then commit → addr 12 dropped; position 3 blank (segment = 0, anode[3] = 0).
- commit issued mid-frame with rotation due at the same frame end → wr_ready low until the frame end, then offset = 0 and no rotation step; a second commit while PENDING has no effect.
- Reset pulsed during PENDING → anode = 4'hF asynchronously, commit discarded, active buffer blank.

Source files
------------

// File: rtl/banner_pkg.sv
// Shared constants and types for the banner scan controller.
// Pure definitions: no latency, no flow control.
package banner_pkg;
  localparam int MSG_LEN_MAX = 16;

  typedef logic [3:0] char_t;
  typedef enum logic {IDLE, PENDING} commit_state_t;

  localparam char_t      BLANK_CODE = 4'hF;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;

  // One-cold anode pattern for display position pos (3 = leftmost).
  function automatic logic [3:0] anode_for_pos(input logic [1:0] pos);
    return ~(4'b0001 << pos);
  endfunction
endpackage

// File: rtl/banner_scan_timer.sv
// Digit-slot prescaler and slot index (3 down to 0); strobes slot_tick and frame_end.
// Strobes are combinational from registered counters; free-running, no backpressure.
module banner_scan_timer #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_slot_tick,
  output logic       o_frame_end,
  output logic [1:0] o_slot_nxt
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_slot;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

  // Slot index decrements and wraps 0 -> 3 through natural 2-bit overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_slot  <= 2'd3;
    end else if (w_tick) begin
      r_presc <= '0;
      r_slot  <= r_slot - 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign o_slot_tick = w_tick;
  assign o_frame_end = w_tick && (r_slot == 2'd0);
  assign o_slot_nxt  = r_slot - 2'd1;
endmodule

// File: rtl/seg7_decoder.sv
// 4-bit code to active-high 7-segment pattern (bit0 = a .. bit6 = g); codes 10-15 blank.
// Combinational, no backpressure.
module seg7_decoder (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h00;
    case (i_code)
      4'd0: o_seg = 7'h3F;
      4'd1: o_seg = 7'h06;
      4'd2: o_seg = 7'h5B;
      4'd3: o_seg = 7'h4F;
      4'd4: o_seg = 7'h66;
      4'd5: o_seg = 7'h6D;
      4'd6: o_seg = 7'h7D;
      4'd7: o_seg = 7'h07;
      4'd8: o_seg = 7'h7F;
      4'd9: o_seg = 7'h6F;
      default: o_seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/banner_scan_controller.sv
// 4-digit multiplexed banner: rotating MSG_LEN-char message, shadow buffer committed at frame end.
// Display updates 1 cycle after slot tick (2 with SCAN_GHOST_GUARD_EN); wr_ready low while a commit is pending.
module banner_scan_controller
  import banner_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int ROT_DIV  = 25,
  parameter int MSG_LEN  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  output logic [6:0] segment,
  output logic [3:0] anode,
  output logic [3:0] offset
);
  localparam int RW = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;

  char_t         r_shadow [MSG_LEN];
  char_t         r_active [MSG_LEN];
  commit_state_t r_state, w_state_nxt;
  logic          r_ready;
  logic [RW-1:0] r_rot, w_rot_nxt;
  logic [3:0]    r_offset, w_off_nxt;
  logic [3:0]    r_anode;
  logic [6:0]    r_segment;

  logic          w_tick, w_frame_end, w_copy, w_wr_fire;
  logic [1:0]    w_slot_nxt;
  logic [4:0]    w_sum, w_idx_full;
  logic [3:0]    w_idx, w_anode_new;
  char_t         w_char;
  logic [6:0]    w_seg_dec;

  banner_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .o_slot_tick (w_tick),
    .o_frame_end (w_frame_end),
    .o_slot_nxt  (w_slot_nxt)
  );

  assign w_wr_fire = wr_valid && r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    case (r_state)
      IDLE:    if (commit) w_state_nxt = PENDING;
      PENDING: if (w_frame_end) begin
        w_copy      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A commit landing at a frame end overrides any rotation step due there.
  always_comb begin
    w_rot_nxt = r_rot;
    w_off_nxt = r_offset;
    if (w_copy) begin
      w_rot_nxt = '0;
      w_off_nxt = 4'd0;
    end else if (w_frame_end && en) begin
      if (r_rot == RW'(ROT_DIV - 1)) begin
        w_rot_nxt = '0;
        if (dir) w_off_nxt = (r_offset == 4'(MSG_LEN - 1)) ? 4'd0 : r_offset + 4'd1;
        else     w_off_nxt = (r_offset == 4'd0) ? 4'(MSG_LEN - 1) : r_offset - 4'd1;
      end else begin
        w_rot_nxt = r_rot + RW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ready  <= 1'b0;
      r_rot    <= '0;
      r_offset <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= (w_state_nxt == IDLE);
      r_rot    <= w_rot_nxt;
      r_offset <= w_off_nxt;
    end
  end

  // Writes and the copy never coincide: writes need IDLE, the copy happens in PENDING.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_shadow[i] <= BLANK_CODE;
        r_active[i] <= BLANK_CODE;
      end
    end else begin
      if (w_wr_fire && ({1'b0, wr_addr} < 5'(MSG_LEN))) r_shadow[wr_addr] <= wr_data;
      if (w_copy) begin
        for (int i = 0; i < MSG_LEN; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Select from next-state buffer/offset so each frame shows one consistent view.
  assign w_sum       = {1'b0, w_off_nxt} + 5'd3 - {3'b000, w_slot_nxt};
  assign w_idx_full  = (w_sum >= 5'(MSG_LEN)) ? (w_sum - 5'(MSG_LEN)) : w_sum;
  assign w_idx       = w_idx_full[3:0];
  assign w_char      = w_copy ? r_shadow[w_idx] : r_active[w_idx];
  assign w_anode_new = anode_for_pos(w_slot_nxt);

  seg7_decoder u_dec (
    .i_code (w_char),
    .o_seg  (w_seg_dec)
  );

`ifdef SCAN_GHOST_GUARD_EN
  logic       r_ghost;
  logic [3:0] r_pend_anode;
  logic [6:0] r_pend_seg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_anode      <= ANODE_OFF;
      r_segment    <= 7'h00;
      r_ghost      <= 1'b0;
      r_pend_anode <= ANODE_OFF;
      r_pend_seg   <= 7'h00;
    end else if (w_tick) begin
      r_anode      <= ANODE_OFF;
      r_segment    <= 7'h00;
      r_ghost      <= 1'b1;
      r_pend_anode <= w_anode_new;
      r_pend_seg   <= w_seg_dec;
    end else if (r_ghost) begin
      r_anode   <= r_pend_anode;
      r_segment <= r_pend_seg;
      r_ghost   <= 1'b0;
    end
  end
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_anode   <= ANODE_OFF;
      r_segment <= 7'h00;
    end else if (w_tick) begin
      r_anode   <= w_anode_new;
      r_segment <= w_seg_dec;
    end
  end
`endif

  assign anode    = r_anode;
  assign segment  = r_segment;
  assign offset   = r_offset;
  assign wr_ready = r_ready;
endmodule

// File: tb/tb_banner_scan_controller.sv
// Directed + randomized bench for banner_scan_controller (default build) against a frame-level model.
module tb_banner_scan_controller;
  localparam int SD = 4;
  localparam int RD = 2;
  localparam int ML = 10;
  localparam int FRAME = 4 * SD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, dir = 1'b0, wr_valid = 1'b0, commit = 1'b0;
  logic [3:0] wr_addr = 4'd0, wr_data = 4'd0;
  logic       wr_ready;
  logic [6:0] segment;
  logic [3:0] anode, offset;

  banner_scan_controller #(.SCAN_DIV(SD), .ROT_DIV(RD), .MSG_LEN(ML)) dut (
    .clock(clock), .reset(reset), .en(en), .dir(dir),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .segment(segment), .anode(anode), .offset(offset)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_lut [16];
  logic [3:0] m_shadow [16];
  logic [3:0] m_active [ML];
  int         m_edge, m_off, m_rot;
  bit         m_pend, m_ready;
  logic [3:0] m_anode;
  logic [6:0] m_seg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_shadow[i] = 4'hF;
    for (int i = 0; i < ML; i++) m_active[i] = 4'hF;
    m_edge = 0; m_off = 0; m_rot = 0; m_pend = 0; m_ready = 0;
    m_anode = 4'hF; m_seg = 7'h00;
  endtask

  // One clock: advance the model on the edge, compare all outputs 1 time unit later.
  task automatic cycle();
    bit         pend0;
    int         k, p;
    logic [3:0] one;
    one = 4'b0001;
    @(posedge clock);
    m_edge++;
    pend0 = m_pend;
    if (wr_valid && m_ready && wr_addr < ML) m_shadow[wr_addr] = wr_data;
    if (m_edge % FRAME == 0) begin
      if (pend0) begin
        for (int i = 0; i < ML; i++) m_active[i] = m_shadow[i];
        m_off = 0; m_rot = 0; m_pend = 0;
      end else if (en) begin
        m_rot++;
        if (m_rot == RD) begin
          m_rot = 0;
          m_off = dir ? (m_off + 1) % ML : (m_off + ML - 1) % ML;
        end
      end
    end
    if (!pend0 && commit) m_pend = 1;
    m_ready = !m_pend;
    if (m_edge % SD == 0) begin
      k = m_edge / SD;
      p = 3 - (k % 4);
      m_anode = ~(one << p);
      m_seg = seg_lut[m_active[(m_off + 3 - p) % ML]];
    end
    #1;
    chk("anode", anode, m_anode);
    chk("segment", segment, m_seg);
    chk("offset", offset, m_off);
    chk("wr_ready", wr_ready, m_ready);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic to_frame_end();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (m_edge % FRAME != 0 && n < 2 * FRAME);
  endtask

  task automatic wait_anode(input logic [3:0] pat, input string tag);
    int n = 0;
    while (anode !== pat && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    chk(tag, anode, pat);
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_anode", anode, 4'hF);
    chk("rst_segment", segment, 7'h00);
    chk("rst_offset", offset, 4'd0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    seg_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    #2;
    do_reset();
    cycle();

    // Load "0123456789" and commit.
    for (int i = 0; i < ML; i++) write(4'(i), 4'(i));
    pulse_commit();
    to_frame_end();
    wait_anode(4'b0111, "commit_pos3");
    chk("digit0_seg", segment, 7'h3F);
    wait_anode(4'b1011, "commit_pos2");
    chk("digit1_seg", segment, 7'h06);

    // Rotate left.
    to_frame_end();
    en = 1'b1; dir = 1'b1;
    to_frame_end();
    to_frame_end();
    chk("left_off1", offset, 4'd1);
    chk("left_pos3_is1", segment, 7'h06);
    wait_anode(4'b1110, "left_pos0");
    chk("left_pos0_is4", segment, 7'h66);
    to_frame_end();
    for (int i = 0; i < 15; i++) to_frame_end();
    chk("left_off9", offset, 4'd9);
    chk("off9_pos3_is9", segment, 7'h6F);
    wait_anode(4'b1110, "off9_pos0");
    chk("off9_pos0_is2", segment, 7'h5B);
    to_frame_end();
    to_frame_end();
    chk("left_wrap0", offset, 4'd0);

    // Rotate right from 0, then freeze.
    dir = 1'b0;
    to_frame_end();
    to_frame_end();
    chk("right_wrap9", offset, 4'd9);
    en = 1'b0;
    for (int i = 0; i < 10; i++) to_frame_end();
    chk("frozen9", offset, 4'd9);

    // Out-of-range address dropped; blank code at position 3.
    write(4'd12, 4'd5);
    write(4'd0, 4'hB);
    pulse_commit();
    to_frame_end();
    chk("blank_anode3", anode, 4'b0111);
    chk("blank_seg", segment, 7'h00);
    chk("blank_off0", offset, 4'd0);

    // Commit against a rotation step due at the same frame end.
    en = 1'b1; dir = 1'b1;
    to_frame_end();
    run(5);
    pulse_commit();
    chk("pend_ready_low", wr_ready, 1'b0);
    run(3);
    pulse_commit();
    to_frame_end();
    chk("commit_wins_off", offset, 4'd0);
    chk("commit_done_ready", wr_ready, 1'b1);
    to_frame_end();
    chk("rot_restart_off", offset, 4'd0);
    to_frame_end();
    chk("rot_after_commit", offset, 4'd1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if (i % 24 == 0) begin
        en  = ($urandom_range(0, 3) != 0);
        dir = 1'($urandom_range(0, 1));
      end
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 4'($urandom_range(0, 15));
      commit   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    wr_valid = 1'b0; commit = 1'b0; en = 1'b0;
    to_frame_end();

    // Reset during PENDING discards the commit.
    write(4'd3, 4'd7);
    pulse_commit();
    run(3);
    do_reset();
    run(2 * FRAME);
    wait_anode(4'b0111, "post_rst_pos3");
    chk("post_rst_blank", segment, 7'h00);
    chk("post_rst_off", offset, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
